// File: rtl/board_port_arbiter_if.sv
// Game-side access handshake and RAM port B bus.
// slave is the arbiter's view; master is the game engine / RAM side.
interface board_port_arbiter_if;
   logic       game_req;
   logic       game_we;
   logic [4:0] game_x;
   logic [3:0] game_y;
   logic [3:0] game_wdata;
   logic       game_gnt;
   logic       game_rvalid;
   logic [3:0] game_rdata;
   logic [4:0] ram_x;
   logic [3:0] ram_y;
   logic [3:0] ram_in;
   logic       ram_rd;
   logic       ram_wr;
   logic [3:0] ram_out;

   modport slave (
      input  game_req, game_we, game_x, game_y, game_wdata, ram_out,
      output game_gnt, game_rvalid, game_rdata,
      output ram_x, ram_y, ram_in, ram_rd, ram_wr
   );

   modport master (
      output game_req, game_we, game_x, game_y, game_wdata, ram_out,
      input  game_gnt, game_rvalid, game_rdata,
      input  ram_x, ram_y, ram_in, ram_rd, ram_wr
   );
endinterface

// File: rtl/board_port_arbiter.sv
// RAM port B owner: clear sweeper, round-robin game/EPP arbitration and
// the EPP row-major load cursor. All port B outputs are registered.
module board_port_arbiter #(
   parameter int unsigned BOARD_W   = 20,
   parameter int unsigned BOARD_H   = 15,
   parameter logic [3:0]  CLEAR_VAL = 4'd0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear_req,
   output logic                       busy,
   input  logic                       epp_wr,
   input  logic [3:0]                 epp_data,
   input  logic                       epp_ptr_rst,
   output logic                       epp_ovf,
   output logic                       load_done,
   board_port_arbiter_if.slave        bus
);

   localparam logic [4:0] X_LAST = 5'(BOARD_W - 1);
   localparam logic [3:0] Y_LAST = 4'(BOARD_H - 1);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t     state_q, state_d;
   logic [4:0] clr_x_q, cur_x_q;
   logic [3:0] clr_y_q, cur_y_q;
   logic       pend_q;
   logic [3:0] pend_data_q;
   logic       rr_epp_q;
   logic       ovf_q;

   logic       acc_valid, acc_we;
   logic [4:0] acc_x;
   logic [3:0] acc_y, acc_data;
   logic       grant_game, issue_epp, game_elig;
   logic       clr_last, cur_last;

   assign clr_last = (clr_x_q == X_LAST) && (clr_y_q == Y_LAST);
   assign cur_last = (cur_x_q == X_LAST) && (cur_y_q == Y_LAST);

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // The game is ineligible while its grant is on the bus, so it can
   // issue at most every other cycle.
   always_comb begin
      state_d    = state_q;
      acc_valid  = 1'b0;
      acc_we     = 1'b0;
      acc_x      = '0;
      acc_y      = '0;
      acc_data   = '0;
      grant_game = 1'b0;
      issue_epp  = 1'b0;
      game_elig  = bus.game_req && !bus.game_gnt;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) state_d = ST_CLEAR;
            if (game_elig && !(pend_q && rr_epp_q)) grant_game = 1'b1;
            else if (pend_q)                        issue_epp  = 1'b1;
         end
         ST_CLEAR: begin
            acc_valid = 1'b1;
            acc_we    = 1'b1;
            acc_x     = clr_x_q;
            acc_y     = clr_y_q;
            acc_data  = CLEAR_VAL;
            if (clr_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (grant_game) begin
         acc_valid = 1'b1;
         acc_we    = bus.game_we;
         acc_x     = bus.game_x;
         acc_y     = bus.game_y;
         acc_data  = bus.game_wdata;
      end else if (issue_epp) begin
         acc_valid = 1'b1;
         acc_we    = 1'b1;
         acc_x     = cur_x_q;
         acc_y     = cur_y_q;
         acc_data  = pend_data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.ram_x       <= '0;
         bus.ram_y       <= '0;
         bus.ram_in      <= '0;
         bus.ram_rd      <= 1'b0;
         bus.ram_wr      <= 1'b0;
         bus.game_gnt    <= 1'b0;
         bus.game_rvalid <= 1'b0;
         load_done       <= 1'b0;
         rr_epp_q        <= 1'b0;
         clr_x_q         <= '0;
         clr_y_q         <= '0;
         cur_x_q         <= '0;
         cur_y_q         <= '0;
         pend_q          <= 1'b0;
         pend_data_q     <= '0;
         ovf_q           <= 1'b0;
      end else begin
         bus.ram_x       <= acc_x;
         bus.ram_y       <= acc_y;
         bus.ram_in      <= acc_data;
         bus.ram_rd      <= acc_valid && !acc_we;
         bus.ram_wr      <= acc_valid && acc_we;
         bus.game_gnt    <= grant_game;
         // ram_rd is only ever a game read, so its echo marks read data.
         bus.game_rvalid <= bus.ram_rd;
         load_done       <= issue_epp && cur_last;

         if (grant_game)     rr_epp_q <= 1'b1;
         else if (issue_epp) rr_epp_q <= 1'b0;

         if (state_q == ST_CLEAR) begin
            if (clr_x_q == X_LAST) begin
               clr_x_q <= '0;
               clr_y_q <= (clr_y_q == Y_LAST) ? '0 : clr_y_q + 4'd1;
            end else begin
               clr_x_q <= clr_x_q + 5'd1;
            end
         end

         if (epp_ptr_rst) begin
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= epp_wr;
            pend_data_q <= epp_data;
         end else begin
            if (issue_epp) begin
               pend_q <= 1'b0;
               if (cur_x_q == X_LAST) begin
                  cur_x_q <= '0;
                  cur_y_q <= (cur_y_q == Y_LAST) ? '0 : cur_y_q + 4'd1;
               end else begin
                  cur_x_q <= cur_x_q + 5'd1;
               end
            end
            if (epp_wr) begin
               if (pend_q && !issue_epp) begin
                  ovf_q <= 1'b1;
               end else begin
                  pend_q      <= 1'b1;
                  pend_data_q <= epp_data;
               end
            end
         end
      end
   end

   assign busy           = (state_q == ST_CLEAR);
   assign epp_ovf        = ovf_q;
   assign bus.game_rdata = bus.game_rvalid ? bus.ram_out : '0;

endmodule

// File: tb/tb_board_port_arbiter.sv
// Directed bench for board_port_arbiter: expected port B accesses are queued
// as stimulus is driven and matched against the bus as it is observed.
module tb_board_port_arbiter;

   typedef struct packed {
      logic       we;
      logic [4:0] x;
      logic [3:0] y;
      logic [3:0] d;
   } acc_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear_req;
   logic       busy;
   logic       epp_wr;
   logic [3:0] epp_data;
   logic       epp_ptr_rst;
   logic       epp_ovf;
   logic       load_done;

   board_port_arbiter_if bus ();

   int   vectors     = 0;
   int   miscompares = 0;
   int   ld_cnt      = 0;
   logic [8:0] ld_xy = '0;
   acc_t exp_q[$];

   logic [3:0] mem [512];
   logic [3:0] ram_q = '0;
   logic       pre_we = 1'b0;
   logic [8:0] pre_addr = '0;
   logic [3:0] pre_d = '0;

   board_port_arbiter #(.BOARD_W(20), .BOARD_H(15), .CLEAR_VAL(4'd0)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear_req   (clear_req),
      .busy        (busy),
      .epp_wr      (epp_wr),
      .epp_data    (epp_data),
      .epp_ptr_rst (epp_ptr_rst),
      .epp_ovf     (epp_ovf),
      .load_done   (load_done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Synchronous RAM model with one-cycle read latency.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_d;
      else if (bus.ram_wr) mem[{bus.ram_y, bus.ram_x}] <= bus.ram_in;
      if (bus.ram_rd) ram_q <= mem[{bus.ram_y, bus.ram_x}];
   end
   assign bus.ram_out = ram_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_acc(input logic we, input logic [4:0] x, input logic [3:0] y, input logic [3:0] d);
      acc_t a;
      a.we = we; a.x = x; a.y = y; a.d = d;
      exp_q.push_back(a);
   endtask

   task automatic push_clear(input int unsigned n);
      for (int unsigned i = 0; i < n; i++)
         push_acc(1'b1, 5'(i % 20), 4'(i / 20), 4'd0);
   endtask

   task automatic drain(input string tag, input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         n++;
         tick();
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic all_zero(input string tag);
      chk(tag, 32'({busy, epp_ovf, load_done, bus.game_gnt, bus.game_rvalid, bus.game_rdata,
                    bus.ram_x, bus.ram_y, bus.ram_in, bus.ram_rd, bus.ram_wr}), 32'd0);
   endtask

   // Scoreboard: every port B access must match the head of the queue.
   always @(negedge clk) begin
      if (bus.ram_wr === 1'b1 || bus.ram_rd === 1'b1) begin
         acc_t e;
         logic [15:0] got, expv;
         got = {bus.ram_wr, bus.ram_rd, bus.ram_x, bus.ram_y, bus.ram_wr ? bus.ram_in : 4'd0};
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            expv = {e.we, !e.we, e.x, e.y, e.we ? e.d : 4'd0};
         end else begin
            expv = '0;
         end
         chk("ram_access", 32'(got), 32'(expv));
      end
      if (load_done === 1'b1) begin
         ld_cnt++;
         ld_xy = {bus.ram_x, bus.ram_y};
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int ld_base;
      rst = 1'b0; clear_req = 1'b0; epp_wr = 1'b0; epp_data = '0; epp_ptr_rst = 1'b0;
      bus.game_req = 1'b0; bus.game_we = 1'b0; bus.game_x = '0; bus.game_y = '0; bus.game_wdata = '0;
      repeat (3) tick();
      all_zero("reset_outputs");
      rst = 1'b1;
      tick();

      // Full clear sweep.
      push_clear(300);
      clear_req = 1'b1; tick(); clear_req = 1'b0;
      n = 0;
      while (busy && n < 1000) begin n++; tick(); end
      chk("clear_busy_len", 32'(n), 32'd300);
      drain("clear_drain", 10);
      repeat (5) tick();
      chk("clear_idle_busy", 32'(busy), 32'd0);

      // Game read of (3,2) returning 9.
      pre_addr = {4'd2, 5'd3}; pre_d = 4'h9; pre_we = 1'b1; tick(); pre_we = 1'b0;
      push_acc(1'b0, 5'd3, 4'd2, 4'd0);
      bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_x = 5'd3; bus.game_y = 4'd2;
      tick();
      chk("read_gnt", 32'(bus.game_gnt), 32'd1);
      chk("read_rd", 32'(bus.ram_rd), 32'd1);
      bus.game_req = 1'b0;
      tick();
      chk("read_rvalid", 32'(bus.game_rvalid), 32'd1);
      chk("read_rdata", 32'(bus.game_rdata), 32'h9);
      chk("read_gnt_low", 32'(bus.game_gnt), 32'd0);
      tick();
      chk("read_rvalid_low", 32'(bus.game_rvalid), 32'd0);

      // One EPP write turns the pointer back to the game, then rewind cursor.
      push_acc(1'b1, 5'd0, 4'd0, 4'h5);
      epp_wr = 1'b1; epp_data = 4'h5; tick(); epp_wr = 1'b0;
      tick(); tick();
      epp_ptr_rst = 1'b1; tick(); epp_ptr_rst = 1'b0; tick();
      drain("prelim_drain", 5);

      // Game and EPP contend: strict alternation starting with the game.
      push_acc(1'b1, 5'd7, 4'd1, 4'hC); push_acc(1'b1, 5'd0, 4'd0, 4'h1);
      push_acc(1'b1, 5'd7, 4'd1, 4'hC); push_acc(1'b1, 5'd1, 4'd0, 4'h2);
      push_acc(1'b1, 5'd7, 4'd1, 4'hC); push_acc(1'b1, 5'd2, 4'd0, 4'h3);
      epp_wr = 1'b1; epp_data = 4'h1; tick(); epp_wr = 1'b0;
      bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_x = 5'd7; bus.game_y = 4'd1; bus.game_wdata = 4'hC;
      tick(); chk("alt_gnt1", 32'(bus.game_gnt), 32'd1);
      epp_wr = 1'b1; epp_data = 4'h2;
      tick(); chk("alt_gnt2", 32'(bus.game_gnt), 32'd0);
      epp_wr = 1'b0;
      tick(); chk("alt_gnt3", 32'(bus.game_gnt), 32'd1);
      epp_wr = 1'b1; epp_data = 4'h3;
      tick(); chk("alt_gnt4", 32'(bus.game_gnt), 32'd0);
      epp_wr = 1'b0;
      tick(); chk("alt_gnt5", 32'(bus.game_gnt), 32'd1);
      bus.game_req = 1'b0;
      tick(); chk("alt_gnt6", 32'(bus.game_gnt), 32'd0);
      drain("alt_drain", 5);
      chk("alt_ovf", 32'(epp_ovf), 32'd0);

      // Full board load through the EPP cursor.
      epp_ptr_rst = 1'b1; tick(); epp_ptr_rst = 1'b0; tick();
      ld_base = ld_cnt;
      for (int i = 0; i < 300; i++) push_acc(1'b1, 5'(i % 20), 4'(i / 20), 4'(i));
      for (int i = 0; i < 300; i++) begin
         epp_wr = 1'b1; epp_data = 4'(i); tick();
         epp_wr = 1'b0; tick();
      end
      drain("load_drain", 10);
      chk("load_done_count", 32'(ld_cnt - ld_base), 32'd1);
      chk("load_done_cell", 32'(ld_xy), 32'({5'd19, 4'd14}));
      chk("load_ovf", 32'(epp_ovf), 32'd0);
      push_acc(1'b1, 5'd0, 4'd0, 4'hA);
      epp_wr = 1'b1; epp_data = 4'hA; tick(); epp_wr = 1'b0;
      drain("cursor_wrap", 5);

      // Overflow while CLEAR blocks the EPP word; cursor now at (1,0).
      push_clear(300);
      push_acc(1'b1, 5'd1, 4'd0, 4'hE);
      clear_req = 1'b1; tick(); clear_req = 1'b0;
      epp_wr = 1'b1; epp_data = 4'hE; tick();
      epp_data = 4'hF; tick();
      epp_wr = 1'b0;
      chk("ovf_set", 32'(epp_ovf), 32'd1);
      drain("ovf_drain", 400);
      chk("ovf_sticky", 32'(epp_ovf), 32'd1);
      epp_ptr_rst = 1'b1; tick(); epp_ptr_rst = 1'b0;
      chk("ovf_cleared", 32'(epp_ovf), 32'd0);
      tick();

      // Reset while cell 57 is being decided aborts the sweep.
      push_clear(57);
      clear_req = 1'b1; tick(); clear_req = 1'b0;
      repeat (57) tick();
      rst = 1'b0; tick();
      all_zero("midsweep_reset");
      rst = 1'b1;
      repeat (5) tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      push_clear(300);
      clear_req = 1'b1; tick(); clear_req = 1'b0;
      n = 0;
      while (busy && n < 1000) begin n++; tick(); end
      chk("restart_busy_len", 32'(n), 32'd300);
      drain("restart_drain", 10);
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/board_port_arbiter.md
Name: board_port_arbiter

Overview:
- Owns RAM port B: shares it between the game engine and the EPP board loader, and adds an internal clear sweeper.
- Sits between the game, EPP and RAM blocks on the mclk domain.
- Sequences all RAM port B accesses.
- Converts the EPP cell stream into row-major board writes through an internal cursor.

Parameters:
- BOARD_W, 20, board columns (x range 0..BOARD_W-1, max 32)
- BOARD_H, 15, board rows (y range 0..BOARD_H-1, max 16)
- CLEAR_VAL, 4'd0, cell value written by the clear sweep

Ports:
- clk  in  1  system clock (mclk domain); single clock
- rst  in  1  reset, synchronous, active-low
- clear_req  in  1  pulse: start clear sweep
- busy  out  1  clear sweep in progress
- epp_wr  in  1  pulse: one EPP cell word valid
- epp_data  in  4  EPP cell value
- epp_ptr_rst  in  1  pulse: reset load cursor to (0,0)
- epp_ovf  out  1  sticky: EPP word lost
- load_done  out  1  pulse: last board cell loaded
- game_req  in  1  game access request, held until game_gnt
- game_we  in  1  1=write, 0=read
- game_x  in  5  cell x
- game_y  in  4  cell y
- game_wdata  in  4  write value
- game_gnt  out  1  pulse: request issued to RAM
- game_rvalid  out  1  pulse: game_rdata valid
- game_rdata  out  4  read data
- ram_x  out  5  port B x
- ram_y  out  4  port B y
- ram_in  out  4  port B write data
- ram_rd  out  1  port B read strobe
- ram_wr  out  1  port B write strobe
- ram_out  in  4  port B read data (1-cycle synchronous RAM)

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0. FSM to IDLE; cursor to (0,0); EPP pending and overflow cleared; round-robin pointer to "game first". Reset mid-sweep or mid-read aborts: no rvalid is produced for an aborted read.
- All ram_* outputs, game_gnt and load_done are registered. An access decided in cycle N drives ram_* in N+1; ram_rd/ram_wr are 1-cycle pulses.
- FSM states: IDLE, CLEAR.
  - IDLE + clear_req -> CLEAR; busy=1 from the next cycle.
  - CLEAR issues one write of CLEAR_VAL per cycle. Order: x inner 0..BOARD_W-1, y outer 0..BOARD_H-1.
  - After cell (BOARD_W-1,BOARD_H-1) is issued -> IDLE; busy drops the following cycle.
  - Sweep length is exactly BOARD_W*BOARD_H writes. clear_req during CLEAR is ignored.
- Priority: CLEAR blocks all other accesses. In IDLE, the game and a pending EPP word are arbitrated round-robin. The pointer flips to the other requester after every grant. A lone requester is served every eligible cycle.
- Game handshake:
  - game_gnt is high in the cycle the access is on ram_*.
  - game_req is not considered in the gnt cycle, so a back-to-back game access is issued at most every other cycle.
  - Read: game_rvalid=1 and game_rdata=ram_out one cycle after ram_rd (gnt+1).
  - No range checking: out-of-board coordinates are passed through.
- EPP path:
  - One-entry pending register, captured on epp_wr. It is issued at cursor (x,y); the cursor advances on issue, x first, then y.
  - Issuing cell (BOARD_W-1,BOARD_H-1) wraps the cursor to (0,0) and pulses load_done in the issue cycle.
  - epp_wr while pending is already full (not freed that cycle): the word is dropped and epp_ovf is set. epp_ovf stays set until reset or epp_ptr_rst.
  - epp_wr in the same cycle the pending word issues is accepted.
  - epp_ptr_rst: cursor to (0,0); pending and epp_ovf cleared.
  - epp_ptr_rst together with epp_wr: the new word is kept, destined for (0,0).
- Width rules: cursor x is 5 bits and y is 4 bits, compared against BOARD_W-1 and BOARD_H-1, never a power-of-2 wrap.

Test Plan:
- Reset released, clear_req pulse -> busy=1 for 300 cycles. 300 ram_wr pulses with ram_in=0, in order (0,0),(1,0)..(19,0),(0,1)..(19,14). Then busy=0 and no further writes.
- Game read (x=3,y=2), ram_out model returns 4'h9 -> ram_rd with ram_x=3, ram_y=2 one cycle after the decision, game_gnt in the same cycle, and game_rvalid=1 with game_rdata=9 the next cycle.
- Game req held while an EPP word is pending, pointer at game -> game granted first, EPP write at (0,0) next, then game again (alternation holds for 6 grants).
- 300 epp_wr words spaced 2 cycles apart -> each cell written in row-major order. load_done pulses once, on cell (19,14); cursor back to (0,0); epp_ovf=0.
- Two epp_wr on consecutive cycles during CLEAR -> first word kept, second dropped, epp_ovf=1. After the sweep, one write of the first word at the cursor. epp_ptr_rst then clears epp_ovf.
- rst=0 asserted mid-sweep at cell 57 -> all outputs 0 the next cycle. No further writes; busy=0; a new clear_req restarts from (0,0).
